// File: rtl/acc_stage.sv
// Burst accumulator: after a start, sums len beats of (data + carry-in) and
// presents the wrapped sum plus a sticky carry-out flag until downstream takes it.
module acc_stage #(
    parameter int WIDTH = 10,
    parameter int LENW  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LENW-1:0]  len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_ovf,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] acc;
    logic             ovf;
    logic [LENW-1:0]  cnt;
    logic [LENW-1:0]  len_q;

    logic             launch;
    logic             accept;
    logic             last_beat;
    logic [LENW-1:0]  cnt_inc;
    logic [WIDTH:0]   sum_ext;

    assign launch    = (state == IDLE) && start && (len != '0);
    assign accept    = (state == ACC) && in_valid;
    assign cnt_inc   = cnt + 1'b1;
    assign last_beat = accept && (cnt_inc == len_q);
    // One extra bit on the adder captures the carry-out that feeds the sticky flag.
    assign sum_ext   = {1'b0, acc} + {1'b0, in_data} + {{WIDTH{1'b0}}, in_cin};

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (launch)    state_nxt = ACC;
            ACC:     if (last_beat) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    // acc/ovf are only rewritten on a launch or an accepted beat, so the result
    // stays visible in DONE and after retiring back to IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc   <= '0;
            ovf   <= 1'b0;
            cnt   <= '0;
            len_q <= '0;
        end else if (launch) begin
            len_q <= len;
            acc   <= '0;
            ovf   <= 1'b0;
            cnt   <= '0;
        end else if (accept) begin
            acc   <= sum_ext[WIDTH-1:0];
            ovf   <= ovf | sum_ext[WIDTH];
            cnt   <= cnt_inc;
        end
    end

    always_comb begin
        in_ready  = (state == ACC);
        out_valid = (state == DONE);
        busy      = (state != IDLE);
        out_sum   = acc;
        out_ovf   = ovf;
    end

endmodule

// File: tb/tb_acc_stage.sv
// Randomized bench for acc_stage: bursts are driven and compared against a
// plain integer running-sum model of the accumulate-and-wrap behaviour.
module tb_acc_stage;

    localparam int WIDTH = 10;
    localparam int LENW  = 4;
    localparam int MODV  = 1 << WIDTH;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [LENW-1:0]  len;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_ovf;
    logic             busy;

    int total = 0;
    int bad   = 0;

    int bd[16];
    int bc[16];

    // observations from the most recent burst
    logic             o_lat_valid;
    logic             o_done_ready;
    logic [WIDTH-1:0] o_sum;
    logic             o_ovf;
    bit               o_ready_ok;
    bit               o_hold_ok;
    bit               o_idle_ok;

    acc_stage #(.WIDTH(WIDTH), .LENW(LENW)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_cin(in_cin),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .out_ovf(out_ovf), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference: running integer sum of data+cin, wrapped; any wrap sets ovf.
    function automatic void ref_model(input int n, output int s, output bit o);
        s = 0;
        o = 1'b0;
        for (int i = 0; i < n; i++) begin
            s = s + bd[i] + bc[i];
            if (s >= MODV) begin
                o = 1'b1;
                s = s - MODV;
            end
        end
    endfunction

    // Drives one burst; inputs change on negedge, outputs sampled on negedge.
    task automatic do_burst(input int n, input int gap, input int hold);
        start = 1'b1;
        len   = LENW'(n);
        @(negedge clk);
        start = 1'b0;
        o_ready_ok = 1'b1;
        for (int i = 0; i < n; i++) begin
            for (int g = 0; g < gap; g++) begin
                in_valid = 1'b0;
                in_data  = WIDTH'($urandom);
                in_cin   = 1'($urandom);
                if (in_ready !== 1'b1 || busy !== 1'b1) o_ready_ok = 1'b0;
                @(negedge clk);
            end
            if (in_ready !== 1'b1 || busy !== 1'b1) o_ready_ok = 1'b0;
            in_valid = 1'b1;
            in_data  = WIDTH'(bd[i]);
            in_cin   = 1'(bc[i]);
            @(negedge clk);
            in_valid = 1'b0;
        end
        o_lat_valid  = out_valid;
        o_done_ready = in_ready;
        o_sum        = out_sum;
        o_ovf        = out_ovf;
        o_hold_ok    = 1'b1;
        for (int h = 0; h < hold; h++) begin
            out_ready = 1'b0;
            in_valid  = 1'($urandom);
            @(negedge clk);
            if (out_valid !== 1'b1 || out_sum !== o_sum || out_ovf !== o_ovf || in_ready !== 1'b0)
                o_hold_ok = 1'b0;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        o_idle_ok = (out_valid === 1'b0) && (busy === 1'b0) && (in_ready === 1'b0) &&
                    (out_sum === o_sum) && (out_ovf === o_ovf);
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0; in_data = '0;
        in_cin = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        total++;
        if ({in_ready, out_valid, out_sum, out_ovf, busy} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got rdy=%b vld=%b sum=%0d ovf=%b busy=%b, want all 0",
                     in_ready, out_valid, out_sum, out_ovf, busy);
        end
    endtask

    task automatic check_burst(input string nm, input int n, input int exp_s, input bit exp_o);
        total++;
        if (o_ready_ok !== 1'b1) begin
            bad++; $display("FAIL %s_in_ready: in_ready/busy not high during ACC", nm);
        end
        total++;
        if (o_lat_valid !== 1'b1 || o_done_ready !== 1'b0) begin
            bad++; $display("FAIL %s_latency: out_valid=%b in_ready=%b after last beat, want 1/0",
                            nm, o_lat_valid, o_done_ready);
        end
        total++;
        if (o_sum !== WIDTH'(exp_s)) begin
            bad++; $display("FAIL %s_sum: got %0d want %0d (len %0d)", nm, o_sum, exp_s, n);
        end
        total++;
        if (o_ovf !== exp_o) begin
            bad++; $display("FAIL %s_ovf: got %b want %b", nm, o_ovf, exp_o);
        end
        total++;
        if (o_hold_ok !== 1'b1) begin
            bad++; $display("FAIL %s_hold: result not stable while out_ready low", nm);
        end
        total++;
        if (o_idle_ok !== 1'b1) begin
            bad++; $display("FAIL %s_retire: got vld=%b busy=%b sum=%0d ovf=%b, want 0/0/%0d/%b",
                            nm, out_valid, busy, out_sum, out_ovf, exp_s, exp_o);
        end
    endtask

    task automatic test_basic();
        bd[0] = 100; bd[1] = 200; bd[2] = 300;
        bc[0] = 0;   bc[1] = 0;   bc[2] = 0;
        do_burst(3, 0, 0);
        check_burst("basic", 3, 600, 1'b0);
    endtask

    task automatic test_wrap();
        int s; bit o;
        bd[0] = 1000; bd[1] = 30; bc[0] = 0; bc[1] = 0;
        ref_model(2, s, o);
        do_burst(2, 0, 1);
        check_burst("wrap2", 2, 6, 1'b1);
        total++;
        if (s != 6 || o != 1'b1) begin
            bad++; $display("FAIL wrap2_model: model %0d/%b want 6/1", s, o);
        end
        bd[0] = 1023; bc[0] = 1;
        do_burst(1, 0, 0);
        check_burst("wrap1", 1, 0, 1'b1);
    endtask

    task automatic test_gaps_backpressure();
        int s; bit o;
        bd[0] = $urandom_range(0, MODV - 1); bc[0] = $urandom_range(0, 1);
        bd[1] = $urandom_range(0, MODV - 1); bc[1] = $urandom_range(0, 1);
        ref_model(2, s, o);
        do_burst(2, 3, 5);
        check_burst("gaps", 2, s, o);
    endtask

    task automatic test_len_zero();
        start = 1'b1; len = '0;
        @(negedge clk);
        start = 1'b0;
        total++;
        if (busy !== 1'b0 || in_ready !== 1'b0) begin
            bad++; $display("FAIL len0_first: busy=%b in_ready=%b want 0/0", busy, in_ready);
        end
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
            bad++; $display("FAIL len0_after: busy=%b in_ready=%b vld=%b want 0/0/0",
                            busy, in_ready, out_valid);
        end
    endtask

    task automatic test_start_in_done();
        int s; bit o;
        bd[0] = 7; bd[1] = 9; bc[0] = 1; bc[1] = 0;
        ref_model(2, s, o);
        start = 1'b1; len = 4'd2;
        @(negedge clk);
        start = 1'b1; len = 4'd5;   // held during ACC: must be ignored
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_data = WIDTH'(bd[i]); in_cin = 1'(bc[i]);
            @(negedge clk);
        end
        in_valid = 1'b0;
        start = 1'b1; len = 4'd3; out_ready = 1'b1;
        total++;
        if (out_valid !== 1'b1 || out_sum !== WIDTH'(s) || out_ovf !== o) begin
            bad++; $display("FAIL sid_done: vld=%b sum=%0d ovf=%b want 1/%0d/%b",
                            out_valid, out_sum, out_ovf, s, o);
        end
        @(negedge clk);
        start = 1'b0; out_ready = 1'b0;
        total++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || out_sum !== WIDTH'(s)) begin
            bad++; $display("FAIL sid_retire: busy=%b vld=%b sum=%0d want 0/0/%0d",
                            busy, out_valid, out_sum, s);
        end
        @(negedge clk);
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL sid_not_started: busy=%b want 0", busy);
        end
    endtask

    task automatic test_reset_mid();
        start = 1'b1; len = 4'd4;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_data = WIDTH'(400 + i); in_cin = 1'b1;
            @(negedge clk);
        end
        rst = 1'b1; in_valid = 1'b1; start = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0; start = 1'b0; out_ready = 1'b0;
        total++;
        if ({in_ready, out_valid, out_sum, out_ovf, busy} !== '0) begin
            bad++; $display("FAIL rstmid_outputs: rdy=%b vld=%b sum=%0d ovf=%b busy=%b want all 0",
                            in_ready, out_valid, out_sum, out_ovf, busy);
        end
        bd[0] = 5; bc[0] = 0;
        do_burst(1, 0, 0);
        check_burst("rstmid_new", 1, 5, 1'b0);
    endtask

    task automatic test_random();
        int s; bit o; int n;
        for (int k = 0; k < 10; k++) begin
            n = (k == 0) ? 15 : $urandom_range(1, 15);
            for (int i = 0; i < n; i++) begin
                bd[i] = (k == 0) ? MODV - 1 : $urandom_range(0, MODV - 1);
                bc[i] = (k == 0) ? 1 : $urandom_range(0, 1);
            end
            ref_model(n, s, o);
            do_burst(n, $urandom_range(0, 2), $urandom_range(0, 3));
            check_burst("rand", n, s, o);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_gaps_backpressure();
        test_len_zero();
        test_start_in_done();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/acc_stage.md
ACC_STAGE -- requirements
Module: acc_stage

Interface
REQ-001 SHALL have parameter WIDTH, default 10, giving the data and accumulator width in bits.
REQ-002 SHALL have parameter LENW, default 4, giving the width of the beat-count field.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-005 SHALL have port start  input  1  begin a burst; honoured only in IDLE.
REQ-006 SHALL have port len  input  LENW  number of beats per burst; sampled when start is honoured.
REQ-007 SHALL have port in_valid  input  1  upstream beat valid.
REQ-008 SHALL have port in_ready  output  1  stage accepts a beat.
REQ-009 SHALL have port in_data  input  WIDTH  addend for the beat.
REQ-010 SHALL have port in_cin  input  1  carry-in for the beat.
REQ-011 SHALL have port out_valid  output  1  result available.
REQ-012 SHALL have port out_ready  input  1  downstream takes the result.
REQ-013 SHALL have port out_sum  output  WIDTH  accumulated sum, modulo 2^WIDTH.
REQ-014 SHALL have port out_ovf  output  1  sticky flag; set if any beat produced a carry-out.
REQ-015 SHALL have port busy  output  1  high in ACC and DONE.

Function
REQ-016 SHALL implement FSM states IDLE, ACC and DONE.
REQ-017 In IDLE, start=1 with len!=0 SHALL latch len and clear acc, ovf and cnt, then enter ACC next cycle.
REQ-018 In IDLE, start=1 with len==0 SHALL be ignored; the FSM stays in IDLE.
REQ-019 start in ACC or DONE SHALL be ignored.
REQ-020 in_ready SHALL be 1 only in ACC and SHALL be a registered-state decode, never combinational on in_valid.
REQ-021 A beat SHALL be accepted on a cycle with in_valid && in_ready.
REQ-022 On an accepted beat: {c, acc} <= acc + in_data + in_cin (WIDTH+1-bit sum); ovf <= ovf | c; cnt <= cnt + 1.
REQ-023 Beats with in_valid=0 in ACC SHALL leave acc, ovf and cnt unchanged.
REQ-024 The beat that makes cnt equal the latched len SHALL be the last; the FSM enters DONE on the next edge.
REQ-025 Latency: out_valid SHALL assert the cycle after the last beat is accepted.
REQ-026 In DONE: out_valid=1, out_sum=acc, out_ovf=ovf, in_ready=0; outputs SHALL be held stable until out_ready=1.
REQ-027 DONE with out_ready=1 SHALL return to IDLE next cycle; out_valid deasserts and out_sum/out_ovf hold their last values.
REQ-028 Arithmetic SHALL wrap modulo 2^WIDTH; ovf SHALL never clear within a burst.
REQ-029 The maximum burst is 2^LENW-1 beats; cnt SHALL not overflow.
REQ-030 start and out_ready asserted in the same DONE cycle SHALL only retire the result; start SHALL not be honoured until IDLE.

Reset
REQ-031 rst=1 SHALL force the FSM to IDLE and clear acc, ovf, cnt and latched len to 0 on the next edge, regardless of state, including mid-burst.
REQ-032 After reset: in_ready=0, out_valid=0, out_sum=0, out_ovf=0, busy=0.
REQ-033 rst SHALL take priority over start, in_valid and out_ready in the same cycle.

Verification
REQ-034 len=3; beats 100, 200, 300 with cin=0, no gaps -> out_valid one cycle after third beat; out_sum=600, out_ovf=0.
REQ-035 len=2; beats 1000, 30 -> out_sum=6, out_ovf=1; len=1, beat 1023 with cin=1 -> out_sum=0, out_ovf=1.
REQ-036 len=2 with in_valid gaps of 3 cycles between beats, then out_ready held low 5 cycles -> out_sum stable and out_valid=1 throughout; IDLE one cycle after out_ready=1.
REQ-037 start with len=0 -> busy stays 0 and in_ready stays 0.
REQ-038 rst asserted after 2 of 4 beats -> next cycle all outputs are 0; a new len=1 burst with beat 5 -> out_sum=5, out_ovf=0.
